// File: rtl/param_shift_register_pkg.sv
// Shared types for the parametrised shift register: operation codes and FSM states.
package param_shift_register_pkg;

  typedef enum logic [2:0] {
    OP_HOLD  = 3'b000,
    OP_LOAD  = 3'b001,
    OP_SHL   = 3'b010,
    OP_SHR   = 3'b011,
    OP_ROL   = 3'b100,
    OP_ROR   = 3'b101,
    OP_ASR   = 3'b110,
    OP_CLEAR = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic logic is_shift_op(op_e op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) ||
           (op == OP_ROR) || (op == OP_ASR);
  endfunction

endpackage

// File: rtl/param_shift_register_shift_step_unit.sv
// One single-bit shift/rotate step: returns the next register word and the bit that left it.
module shift_step_unit
  import param_shift_register_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] q,
  input  logic             serial_in,
  output logic [WIDTH-1:0] next_q,
  output logic             out_bit
);

  always_comb begin
    next_q  = q;
    out_bit = 1'b0;
    case (op)
      OP_SHL: begin
        next_q  = {q[WIDTH-2:0], serial_in};
        out_bit = q[WIDTH-1];
      end
      OP_SHR: begin
        next_q  = {serial_in, q[WIDTH-1:1]};
        out_bit = q[0];
      end
      OP_ROL: begin
        next_q  = {q[WIDTH-2:0], q[WIDTH-1]};
        out_bit = q[WIDTH-1];
      end
      OP_ROR: begin
        next_q  = {q[0], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      OP_ASR: begin
        next_q  = {q[WIDTH-1], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      default: begin
        next_q  = q;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/param_shift_register.sv
// WIDTH-bit register with load/clear and multi-step shift/rotate, driven by a start/busy/done handshake.
// Handshake: start is sampled only while busy=0; done is a one-cycle pulse after the finishing edge and never overlaps busy.
module param_shift_register
  import param_shift_register_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] d,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             busy,
  output logic             done,
  output state_e           state_dbg
);

  localparam logic [CNT_W-1:0] MAX_AMT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_e           state, next_state;
  op_e              op_q, op_next, mode_op;
  logic [CNT_W-1:0] cnt, cnt_next, amt_clamped;
  logic [WIDTH-1:0] q_next, step_q;
  logic             so_next, done_next, step_bit;

  assign mode_op     = op_e'(mode);
  assign amt_clamped = (amount > MAX_AMT) ? MAX_AMT : amount;

  shift_step_unit #(.WIDTH(WIDTH)) u_step (
    .op        (op_q),
    .q         (q),
    .serial_in (serial_in),
    .next_q    (step_q),
    .out_bit   (step_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:
        if (start && is_shift_op(mode_op) && (amt_clamped != '0)) next_state = ST_SHIFT;
      ST_SHIFT:
        if (cnt <= ONE) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Datapath next values; zero-length shifts complete like single-cycle ops.
  always_comb begin
    q_next    = q;
    so_next   = serial_out;
    cnt_next  = cnt;
    op_next   = op_q;
    done_next = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          case (mode_op)
            OP_LOAD:  begin q_next = d;  done_next = 1'b1; end
            OP_CLEAR: begin q_next = '0; done_next = 1'b1; end
            OP_HOLD:  done_next = 1'b1;
            default: begin
              if (amt_clamped == '0) begin
                done_next = 1'b1;
              end else begin
                cnt_next = amt_clamped;
                op_next  = mode_op;
              end
            end
          endcase
        end
      end
      ST_SHIFT: begin
        q_next    = step_q;
        so_next   = step_bit;
        cnt_next  = cnt - ONE;
        done_next = (cnt <= ONE);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q          <= '0;
      serial_out <= 1'b0;
      cnt        <= '0;
      op_q       <= OP_HOLD;
      done       <= 1'b0;
    end else begin
      q          <= q_next;
      serial_out <= so_next;
      cnt        <= cnt_next;
      op_q       <= op_next;
      done       <= done_next;
    end
  end

  assign busy      = (state == ST_SHIFT);
  assign state_dbg = state;

endmodule

// File: tb/tb_param_shift_register.sv
// Bench for param_shift_register: directed cases from the block's usage notes plus random operations vs an arithmetic model.
module tb_param_shift_register;
  import param_shift_register_pkg::*;

  localparam int W   = 8;
  localparam int CW  = $clog2(W + 1);
  localparam int TOP = 1 << W;

  logic          clk = 1'b0;
  logic          rst, start, serial_in, serial_out, busy, done;
  logic [2:0]    mode;
  logic [CW-1:0] amount;
  logic [W-1:0]  d, q;
  state_e        state_dbg;

  typedef struct {
    logic [W-1:0] q;
    logic         so;
    int           done_cyc;
    int           busy_len;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           busy_run = 0;
  logic [W-1:0] m_q = '0;
  logic         m_so = 1'b0;

  param_shift_register #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .amount     (amount),
    .d          (d),
    .serial_in  (serial_in),
    .q          (q),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one step expressed as integer arithmetic on the word value.
  function automatic void model_step(input op_e op, input logic [W-1:0] qi, input logic si,
                                     output logic [W-1:0] qo, output logic bo);
    int v, s, msb, lsb;
    v   = int'(qi);
    s   = si ? 1 : 0;
    msb = v / (TOP / 2);
    lsb = v % 2;
    case (op)
      OP_SHL:  begin qo = W'((v * 2 + s) % TOP);              bo = 1'(msb); end
      OP_SHR:  begin qo = W'(v / 2 + s * (TOP / 2));          bo = 1'(lsb); end
      OP_ROL:  begin qo = W'((v * 2) % TOP + msb);            bo = 1'(msb); end
      OP_ROR:  begin qo = W'(v / 2 + lsb * (TOP / 2));        bo = 1'(lsb); end
      OP_ASR:  begin qo = W'(v / 2 + msb * (TOP / 2));        bo = 1'(lsb); end
      default: begin qo = qi;                                 bo = 1'b0;    end
    endcase
  endfunction

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (busy || done) check("busy_done_exclusive", 32'(busy & done), 32'd0);
    if (busy) busy_run++;
    if (done) begin
      if (exp_q.size() == 0) begin
        check("done_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("done_q",        32'(q),          32'(e.q));
        check("done_serial",   32'(serial_out), 32'(e.so));
        check("done_cycle",    32'(cyc),        32'(e.done_cyc));
        check("busy_length",   32'(busy_run),   32'(e.busy_len));
      end
      busy_run = 0;
    end
  end

  // Driver: issue one op at a negedge; returns at the negedge where done is expected.
  // interfere: step index at which a LOAD of all-ones is attempted while busy (-1: none).
  // reset_at: step index at which rst is asserted mid-operation (-1: none).
  task automatic do_op(input op_e op, input int amt, input logic [W-1:0] dv, input logic si,
                       input int interfere, input int reset_at);
    int           n;
    logic [W-1:0] tq[$];
    logic         tso[$];
    logic [W-1:0] mq;
    logic         mso;
    exp_t         e;
    n   = is_shift_op(op) ? ((amt > W) ? W : amt) : 0;
    mq  = m_q;
    mso = m_so;
    if (op == OP_LOAD)  mq = dv;
    if (op == OP_CLEAR) mq = '0;
    for (int i = 0; i < n; i++) begin
      model_step(op, mq, si, mq, mso);
      tq.push_back(mq);
      tso.push_back(mso);
    end
    e.q = mq; e.so = mso; e.done_cyc = cyc + 1 + n; e.busy_len = n;
    exp_q.push_back(e);
    m_q = mq; m_so = mso;
    start = 1'b1; mode = op; amount = CW'(amt); d = dv; serial_in = si;
    @(negedge clk);
    start = 1'b0; mode = 3'($urandom); amount = CW'($urandom); d = W'($urandom);
    for (int i = 0; i < n; i++) begin
      if (i == interfere) begin
        start = 1'b1; mode = OP_LOAD; d = '1;
      end
      if (i == reset_at) rst = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (i == reset_at) begin
        check("rst_mid_q",      32'(q),          32'd0);
        check("rst_mid_busy",   32'(busy),       32'd0);
        check("rst_mid_done",   32'(done),       32'd0);
        check("rst_mid_serial", 32'(serial_out), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        busy_run = 0;
        m_q = '0; m_so = 1'b0;
        return;
      end
      check("step_q",      32'(q),          32'(tq[i]));
      check("step_serial", 32'(serial_out), 32'(tso[i]));
      check("step_busy",   32'(busy),       32'(i < n - 1));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = '0; amount = '0; d = '0; serial_in = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_q",      32'(q),          32'd0);
    check("reset_serial", 32'(serial_out), 32'd0);
    check("reset_busy",   32'(busy),       32'd0);
    check("reset_done",   32'(done),       32'd0);
    check("reset_state",  32'(state_dbg),  32'(ST_IDLE));
    rst = 1'b0;

    do_op(OP_LOAD, 0, 8'b1101_0110, 1'b0, -1, -1);
    check("load_const", 32'(q), 32'hD6);
    do_op(OP_SHL, 3, 8'h00, 1'b0, -1, -1);
    check("shl3_const", 32'(q), 32'hB0);
    check("shl3_so",    32'(serial_out), 32'd0);
    do_op(OP_LOAD, 0, 8'hD6, 1'b0, -1, -1);
    do_op(OP_ROR, 3, 8'h00, 1'b0, -1, -1);
    check("ror3_const", 32'(q), 32'hDA);
    check("ror3_so",    32'(serial_out), 32'd1);
    do_op(OP_LOAD, 0, 8'h9C, 1'b0, -1, -1);
    do_op(OP_ASR, 2, 8'h00, 1'b0, -1, -1);
    check("asr2_const", 32'(q), 32'hE7);
    do_op(OP_LOAD, 0, 8'h9C, 1'b0, -1, -1);
    do_op(OP_SHR, 2, 8'h00, 1'b0, -1, -1);
    check("shr2_const", 32'(q), 32'h27);
    do_op(OP_SHL, 0, 8'h00, 1'b1, -1, -1);
    check("amt0_const", 32'(q), 32'h27);
    do_op(OP_LOAD, 0, 8'hFF, 1'b0, -1, -1);
    do_op(OP_SHR, 15, 8'h00, 1'b0, -1, -1);
    check("clamp_const", 32'(q), 32'h00);
    do_op(OP_LOAD, 0, 8'hA5, 1'b0, -1, -1);
    do_op(OP_ROL, 8, 8'h00, 1'b0, 3, -1);
    check("rol8_const", 32'(q), 32'hA5);
    do_op(OP_CLEAR, 0, 8'h00, 1'b0, -1, -1);
    do_op(OP_LOAD, 0, 8'h5A, 1'b0, -1, -1);
    do_op(OP_SHL, 5, 8'h00, 1'b1, -1, 1);
    do_op(OP_LOAD, 0, 8'h3C, 1'b0, -1, -1);
    check("load_after_rst", 32'(q), 32'h3C);

    for (int k = 0; k < 150; k++) begin
      op_e rop;
      int  ramt;
      rop  = op_e'($urandom_range(0, 7));
      ramt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, W);
      do_op(rop, ramt, W'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0) ? 0 : -1, -1);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
